im_read_arbiter: RTL and testbench
==================================

// Module: im_read_arbiter
// PURPOSE
//  Shares the single instruction-memory read port between the pipeline fetch stage
//  (IF) and a debug/trace reader (DBG). Sits between the fetch stage, debug unit and IM.
//  Fetch has priority. A starvation counter guarantees DBG a slot at a bounded interval.
//  Read data is registered and returned to the granted requester one cycle after grant.
// PARAMETERS
//  ADDR_W      16  instruction address width
//  DATA_W      16  instruction word width
//  STARVE_MAX  4   consecutive cycles DBG may be denied before it is forced (legal >= 1)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       reset, synchronous, active-low
//  if_req      in   1       fetch requests a read this cycle
//  if_addr     in   ADDR_W  fetch address
//  if_gnt      out  1       fetch granted this cycle (combinational)
//  if_stall    out  1       if_req & ~if_gnt; freezes the PC
//  if_rvalid   out  1       if_instr valid (cycle after if_gnt)
//  if_instr    out  DATA_W  registered read data for fetch
//  dbg_req     in   1       debug requests a read; held until granted
//  dbg_addr    in   ADDR_W  debug address; held stable while dbg_req=1
//  dbg_gnt     out  1       debug granted this cycle (combinational)
//  dbg_rvalid  out  1       dbg_instr valid (cycle after dbg_gnt)
//  dbg_instr   out  DATA_W  registered read data for debug
//  im_addr     out  ADDR_W  address to IM
//  im_rd_en    out  1       read enable to IM
//  im_instr    in   DATA_W  IM read data; IM latches it while clk is low, stable by next rising edge
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, starve_cnt=0.
//   if_rvalid, dbg_rvalid, if_instr and dbg_instr all clear to 0.
//   Grants and im_rd_en are 0 while rst_n=0.
//  Grant logic (combinational, one grant per cycle at most):
//   - only if_req          -> if_gnt=1
//   - only dbg_req         -> dbg_gnt=1
//   - both, starve_cnt<STARVE_MAX  -> if_gnt=1
//   - both, starve_cnt==STARVE_MAX -> dbg_gnt=1
//   - neither              -> no grant; im_rd_en=0, im_addr=0
//  IM drive: im_rd_en = if_gnt|dbg_gnt. im_addr = granted requester's address.
//  Starvation counter:
//   - cleared when dbg_gnt or ~dbg_req
//   - +1 when dbg_req & ~dbg_gnt
//   - saturates at STARVE_MAX
//  FSM (owner of the read in flight), next state at posedge:
//   - IDLE   : no grant last cycle
//   - IF_RD  : if_gnt last cycle
//   - DBG_RD : dbg_gnt last cycle
//   - Any state -> IF_RD / DBG_RD / IDLE per the current cycle's grant.
//   - Back-to-back grants allowed; throughput is 1 read per cycle.
//  Return path: at the posedge that ends a grant cycle, im_instr is captured into the
//   owner's *_instr register and that owner's *_rvalid is 1 for exactly the next cycle.
//   The other requester's instr register holds its value. Latency is grant + 1 cycle.
//  if_addr may change every cycle. The value used is the one present in the grant cycle.
//  Reset mid-operation: an in-flight read is dropped (no rvalid after reset).
//   The counter restarts at 0.
//  Widths: starve_cnt is $clog2(STARVE_MAX+1) bits. No other arithmetic.
// TESTING
//  1 Reset: hold rst_n=0 for 2 cycles with if_req=dbg_req=1 -> all grants/rvalids 0,
//    im_rd_en=0. Release -> if_gnt=1 on the first cycle.
//  2 Fetch only: if_addr=0,1,2,3 on consecutive cycles, IM preloaded mem[i]=16'hA000+i ->
//    if_rvalid=1 on cycles 2..5 with if_instr=A000..A003. if_stall=0 throughout.
//  3 Debug only: dbg_addr=16'h0040 for 1 cycle -> dbg_gnt that cycle.
//    Next cycle dbg_rvalid=1, dbg_instr=mem[0x40]. if_rvalid stays 0.
//  4 Contention, STARVE_MAX=4: if_req and dbg_req held high ->
//    pattern IF,IF,IF,IF,DBG repeating. if_stall=1 only on DBG cycles.
//    starve_cnt reads 1,2,3,4,0.
//  5 Simultaneous drop: dbg_req falls at starve_cnt=3 -> counter clears.
//    On re-assert, 4 more IF grants occur before DBG.
//  6 Reset mid-read: assert rst_n=0 on the cycle after if_gnt ->
//    no if_rvalid is produced, if_instr=0.

Source files
------------

// File: rtl/im_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// im_read_arbiter_if
//   Bundles the fetch (IF), debug (DBG) and instruction-memory (IM) signals
//   that meet at the instruction-memory read arbiter.
//
//   Signals
//     if_req / if_addr              fetch read request and address
//     if_gnt / if_stall             fetch grant this cycle, fetch stalled
//     if_rvalid / if_instr          registered read data returned to fetch
//     dbg_req / dbg_addr            debug read request (held until granted)
//     dbg_gnt                       debug grant this cycle
//     dbg_rvalid / dbg_instr        registered read data returned to debug
//     im_addr / im_rd_en / im_instr IM read port
//
//   Modports
//     slave  : the arbiter's view
//     master : the environment's view (fetch stage, debug unit, IM)
// ---------------------------------------------------------------------------
interface im_read_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_stall;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_instr;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_instr;

    logic [ADDR_W-1:0] im_addr;
    logic              im_rd_en;
    logic [DATA_W-1:0] im_instr;

    modport slave (
        input  if_req, if_addr, dbg_req, dbg_addr, im_instr,
        output if_gnt, if_stall, if_rvalid, if_instr,
        output dbg_gnt, dbg_rvalid, dbg_instr,
        output im_addr, im_rd_en
    );

    modport master (
        output if_req, if_addr, dbg_req, dbg_addr, im_instr,
        input  if_gnt, if_stall, if_rvalid, if_instr,
        input  dbg_gnt, dbg_rvalid, dbg_instr,
        input  im_addr, im_rd_en
    );
endinterface

// File: rtl/im_read_arbiter.sv
// ---------------------------------------------------------------------------
// im_read_arbiter
//   Shares the single instruction-memory read port between the fetch stage
//   and a debug/trace reader. Fetch wins on contention, but a starvation
//   counter forces a debug grant once debug has been denied STARVE_MAX
//   consecutive cycles. Read data is captured at the end of the grant cycle
//   and presented to the owner, with its rvalid, for exactly one cycle.
//
//   Ports
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    im_read_arbiter_if.slave (fetch, debug and IM signals)
//
//   Parameters
//     ADDR_W      instruction address width
//     DATA_W      instruction word width
//     STARVE_MAX  debug denials tolerated before debug is forced (>= 1)
// ---------------------------------------------------------------------------
module im_read_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    im_read_arbiter_if.slave       bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    // Index of each requester in the grant vector / return-path generate.
    localparam int REQ_IF  = 0;
    localparam int REQ_DBG = 1;
    localparam int NUM_REQ = 2;

    // Owner of the read currently in flight (i.e. who was granted last cycle).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   starve_cnt_reg, starve_cnt_next;
    logic               if_gnt, dbg_gnt;
    logic [ADDR_W-1:0]  im_addr;
    logic [NUM_REQ-1:0] gnt_vec;

    // -----------------------------------------------------------------------
    // State / counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Grant, IM address, next owner and starvation counter.
    // Everything is held at zero while reset is asserted so no read is issued.
    // -----------------------------------------------------------------------
    always_comb begin
        if_gnt          = 1'b0;
        dbg_gnt         = 1'b0;
        im_addr         = '0;
        state_next      = IDLE;
        starve_cnt_next = '0;

        if (rst_n) begin
            // Debug wins when it is alone or has waited its full allowance.
            if (bus.dbg_req && (!bus.if_req || starve_cnt_reg == STARVE_LIM)) begin
                dbg_gnt = 1'b1;
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end

            if (dbg_gnt) begin
                im_addr    = bus.dbg_addr;
                state_next = DBG_RD;
            end else if (if_gnt) begin
                im_addr    = bus.if_addr;
                state_next = IF_RD;
            end

            // Count consecutive debug denials; any grant or idle debug clears.
            if (bus.dbg_req && !dbg_gnt) begin
                if (starve_cnt_reg == STARVE_LIM) begin
                    starve_cnt_next = STARVE_LIM;
                end else begin
                    starve_cnt_next = starve_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign gnt_vec[REQ_IF]  = if_gnt;
    assign gnt_vec[REQ_DBG] = dbg_gnt;

    // -----------------------------------------------------------------------
    // Return path: one capture register per requester. IM data for the grant
    // cycle's address is stable by the rising edge that ends that cycle.
    // Grants are already forced low under reset, so reset and capture never
    // compete.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ret
            logic [DATA_W-1:0] instr_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    instr_reg <= '0;
                end else if (gnt_vec[gi]) begin
                    instr_reg <= bus.im_instr;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs. rvalid is qualified with rst_n so a read whose completion
    // cycle coincides with reset is dropped rather than reported.
    // -----------------------------------------------------------------------
    assign bus.if_gnt     = if_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.if_stall   = bus.if_req & ~if_gnt;
    assign bus.im_rd_en   = if_gnt | dbg_gnt;
    assign bus.im_addr    = im_addr;

    assign bus.if_rvalid  = rst_n && (state_reg == IF_RD);
    assign bus.dbg_rvalid = rst_n && (state_reg == DBG_RD);
    assign bus.if_instr   = g_ret[REQ_IF].instr_reg;
    assign bus.dbg_instr  = g_ret[REQ_DBG].instr_reg;

endmodule

// File: tb/tb_im_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_im_read_arbiter
//   Self-checking bench for im_read_arbiter (STARVE_MAX = 4).
//   A directed table fixes the expected grants for reset, fetch-only,
//   debug-only and contention traffic; hand-written sequences cover the
//   debug-drop and reset-mid-read cases; a randomized phase takes its
//   expected grants from a small reference model. Returned data and rvalids
//   are always predicted from the expected grant of the previous cycle and
//   the bench's own memory image.
// ---------------------------------------------------------------------------
module tb_im_read_arbiter;

    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    im_read_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    im_read_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory: data appears while clk is low for the current address.
    logic [15:0] mem [0:65535];

    always @(negedge clk) begin
        if (bus.im_rd_en) bus.im_instr <= mem[bus.im_addr];
    end

    typedef struct {
        logic        rn;
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic [15:0] da;
        logic        e_ig;
        logic        e_dg;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Bench-side view of what should be in flight / held.
    logic        sb_known = 1'b0;
    logic        sb_if_pend = 1'b0, sb_dbg_pend = 1'b0;
    logic [15:0] sb_if_instr = '0, sb_dbg_instr = '0;
    int          deny = 0;   // consecutive cycles debug asked and was refused

    function automatic vec_t mk(input logic rn, input logic ir, input logic [15:0] ia,
                                input logic dr, input logic [15:0] da,
                                input logic e_ig, input logic e_dg);
        vec_t v;
        v.rn = rn; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da;
        v.e_ig = e_ig; v.e_dg = e_dg;
        return v;
    endfunction

    // Reference arbitration: fetch first, unless debug has waited SM cycles.
    function automatic vec_t model(input logic rn, input logic ir, input logic [15:0] ia,
                                   input logic dr, input logic [15:0] da);
        logic g_dbg, g_if;
        g_dbg = rn && dr && (!ir || deny >= SM);
        g_if  = rn && ir && !g_dbg;
        return mk(rn, ir, ia, dr, da, g_if, g_dbg);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
    task automatic apply(input vec_t v, input string tag);
        logic [15:0] e_addr;
        rst_n        = v.rn;
        bus.if_req   = v.ir;
        bus.if_addr  = v.ia;
        bus.dbg_req  = v.dr;
        bus.dbg_addr = v.da;
        #3;
        e_addr = v.e_dg ? v.da : (v.e_ig ? v.ia : 16'h0000);
        chk({tag, ".if_gnt"},     32'(bus.if_gnt),     32'(v.e_ig));
        chk({tag, ".dbg_gnt"},    32'(bus.dbg_gnt),    32'(v.e_dg));
        chk({tag, ".if_stall"},   32'(bus.if_stall),   32'(v.ir & ~v.e_ig));
        chk({tag, ".im_rd_en"},   32'(bus.im_rd_en),   32'(v.e_ig | v.e_dg));
        chk({tag, ".im_addr"},    32'(bus.im_addr),    32'(e_addr));
        chk({tag, ".if_rvalid"},  32'(bus.if_rvalid),  32'(v.rn & sb_if_pend));
        chk({tag, ".dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(v.rn & sb_dbg_pend));
        if (sb_known) begin
            chk({tag, ".if_instr"},  32'(bus.if_instr),  32'(sb_if_instr));
            chk({tag, ".dbg_instr"}, 32'(bus.dbg_instr), 32'(sb_dbg_instr));
        end
        $display("cyc=%0d %s rn=%b if_req=%b if_addr=%h dbg_req=%b dbg_addr=%h | if_gnt=%b dbg_gnt=%b im_addr=%h if_rv=%b if_instr=%h dbg_rv=%b dbg_instr=%h",
                 cyc, tag, v.rn, v.ir, v.ia, v.dr, v.da, bus.if_gnt, bus.dbg_gnt,
                 bus.im_addr, bus.if_rvalid, bus.if_instr, bus.dbg_rvalid, bus.dbg_instr);
        @(posedge clk);
        #1;
        cyc++;
        if (!v.rn) begin
            sb_known = 1'b1; sb_if_pend = 1'b0; sb_dbg_pend = 1'b0;
            sb_if_instr = '0; sb_dbg_instr = '0; deny = 0;
        end else begin
            sb_if_pend  = v.e_ig;
            sb_dbg_pend = v.e_dg;
            if (v.e_ig) sb_if_instr  = mem[v.ia];
            if (v.e_dg) sb_dbg_instr = mem[v.da];
            if (v.dr && !v.e_dg) deny = (deny >= SM) ? SM : deny + 1;
            else                 deny = 0;
        end
    endtask

    vec_t tbl[$];

    initial begin
        logic        r_rn, r_ir, r_dr;
        logic [15:0] r_ia, r_da;
        vec_t        v;

        for (int i = 0; i < 65536; i++) mem[i] = 16'hA000 + 16'(i);

        // Reset held with both requesting, then fetch-only 0..3.
        tbl.push_back(mk(0, 1, 16'h0000, 1, 16'h0040, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0000, 1, 16'h0040, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 16'(i), 0, 16'h0000, 1, 0));
        // Debug-only read of 0x40, then idle to see its return.
        tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0040, 0, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0));
        // Contention: IF,IF,IF,IF,DBG repeating.
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1, 1, 16'h0010 + 16'(k), 1, 16'h0080,
                             (k % 5 == 4) ? 1'b0 : 1'b1, (k % 5 == 4) ? 1'b1 : 1'b0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0));

        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.dbg_req = 1'b0; bus.dbg_addr = '0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], "tbl");

        // Debug drops after 3 denials: the wait restarts from zero.
        for (int i = 0; i < 3; i++) apply(mk(1, 1, 16'h0100 + 16'(i), 1, 16'h0200, 1, 0), "drop");
        apply(mk(1, 1, 16'h0103, 0, 16'h0000, 1, 0), "drop");
        for (int i = 0; i < 5; i++)
            apply(mk(1, 1, 16'h0110 + 16'(i), 1, 16'h0201,
                     (i == 4) ? 1'b0 : 1'b1, (i == 4) ? 1'b1 : 1'b0), "drop");
        apply(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0), "drop");

        // Reset in the cycle after a fetch grant: that read never returns.
        apply(mk(1, 1, 16'h0005, 0, 16'h0000, 1, 0), "rstmid");
        apply(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0), "rstmid");
        apply(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0), "rstmid");
        chk("rstmid.if_instr_cleared", 32'(bus.if_instr), 32'h0);

        // Randomized traffic against the reference model.
        r_dr = 1'b0; r_da = '0;
        apply(model(1'b0, 1'b0, 16'h0, 1'b0, 16'h0), "rand");
        for (int n = 0; n < 300; n++) begin
            r_rn = ($urandom_range(0, 39) != 0);
            r_ir = ($urandom_range(0, 9) < 7);
            r_ia = 16'($urandom);
            if (!r_dr && $urandom_range(0, 3) == 0) begin
                r_dr = 1'b1;
                r_da = 16'($urandom);
            end
            v = model(r_rn, r_ir, r_ia, r_dr, r_da);
            apply(v, "rand");
            if (v.e_dg) r_dr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
